ex_mem_latch: RTL and testbench
===============================

Name: ex_mem_latch

Overview:
- EX→MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result, store data and destination register, and registers a branch/jump decision from the ALU's is_zero.
- Stalls the upstream ID/EX stage while a multi-cycle mul/div runs, then releases it on the ALU's one-cycle ready pulse.
- Provides a valid/ready handshake toward MEM with full backpressure.

Parameters:
- DATA_W, 32, datapath width
- CTRL_W, 5, ALU control code width
- RD_W, 5, destination register index width
- MEMCTL_W, 3, opaque memory-op code width, passed through unchanged
- MD_TIMEOUT, 40, mul/div wait cycles before the error flag is raised

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (reset asserted when 1)
- in_valid  in  1  EX holds a valid op
- in_ready  out  1  stage accepts the EX op this cycle
- is_md  in  1  op is MUL..REMU
- is_branch  in  1  op is a branch or JAL/JALR
- alu_result  in  DATA_W  ALU result
- alu_is_zero  in  1  ALU branch-taken/jump flag
- alu_md_ready  in  1  one-cycle mul/div done pulse
- br_target  in  DATA_W  precomputed branch/jump target
- store_data  in  DATA_W  rs2 data for stores
- rd_in  in  RD_W  destination register
- memctl_in  in  MEMCTL_W  memory op code
- stall_ex  out  1  hold ID/EX registers and alu_ctrl stable
- out_valid  out  1  MEM-side payload valid
- out_ready  in  1  MEM accepts the payload
- out_result  out  DATA_W  registered result
- out_store  out  DATA_W  registered store data
- out_rd  out  RD_W  registered destination
- out_memctl  out  MEMCTL_W  registered memory op code
- branch_taken  out  1  one-cycle redirect pulse
- branch_pc  out  DATA_W  redirect target, valid while branch_taken=1
- md_err  out  1  sticky mul/div timeout flag

Behaviour:
- Reset (rst_n=1 at posedge):
  - State returns to IDLE; the wait counter is cleared.
  - All out_* payload, out_valid, branch_taken, branch_pc, stall_ex and md_err are 0.
  - Reset takes priority mid-mul/div: any in-flight result is discarded.
- States:
  - IDLE: no mul/div in flight.
  - MD_WAIT: mul/div in flight, stall asserted.
- Output slot ("slot free"):
  - slot_free = !out_valid || out_ready.
  - in_ready = (state==IDLE) && slot_free && !is_md.
- Single-cycle op, accepted when in_valid && in_ready:
  - At the next edge, load out_result/out_store/out_rd/out_memctl and set out_valid=1.
  - Latency: 1 cycle.
  - If is_branch && alu_is_zero: branch_taken=1 for exactly that next cycle and branch_pc=br_target.
  - A non-taken branch still occupies the slot with rd=0.
- Mul/div start, IDLE with in_valid && is_md:
  - stall_ex=1 combinationally; go to MD_WAIT; counter=0.
- MD_WAIT:
  - stall_ex=1 and in_ready=0; the counter increments each cycle, saturating.
  - On alu_md_ready=1:
    - If slot_free: capture alu_result and the payload at that edge, set out_valid=1, go to IDLE, and drop stall_ex that same cycle, so the ALU cannot restart the unit.
    - If the slot is not free: capture the result into an internal skid register, go to IDLE with a pending flag, keep stall_ex=1 until the skid drains into the slot (next cycle where slot_free), then drop it.
  - Counter reaching MD_TIMEOUT without a ready pulse:
    - Set md_err (sticky until reset).
    - Remain in MD_WAIT; no auto-abort.
- Backpressure:
  - While out_valid && !out_ready, all out_* hold stable.
  - Accept and drain may occur in the same cycle (throughput 1/cycle).
- A ready pulse in IDLE with no pending mul/div is ignored.
- The branch_taken pulse is never repeated while out_valid is held.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- When defined:
  - Adds outputs fwd_valid (1), fwd_rd (RD_W) and fwd_data (DATA_W).
  - fwd_valid = out_valid && out_rd!=0 && memctl indicates no load; fwd_rd/fwd_data mirror out_rd/out_result.
  - Intended for the EX operand bypass.
- When undefined: the ports are absent and no forwarding logic is generated.

Test Plan:
- ADD result 0x0000_0007, rd=5, out_ready=1 → next cycle out_valid=1, out_result=7, out_rd=5, branch_taken=0.
- BEQ with alu_is_zero=1, br_target=0x100 → branch_taken=1 for exactly 1 cycle, branch_pc=0x100.
- MUL with alu_md_ready pulsed on wait cycle 33, result 0x0000_0030 → stall_ex=1 for cycles 0–32, low in the pulse cycle; out_result=0x30 on the next cycle.
- out_ready=0 for 3 cycles with out_valid=1, then a mul/div ready pulse → out_* stay stable, the skid holds the result, stall_ex stays high until the drain, and the result appears in order after the held payload.
- Mul/div started, no ready pulse for 40 cycles → md_err=1 at cycle 40 and remains set; rst_n=1 → md_err=0, state IDLE, out_valid=0.
- Back-to-back ADDs with out_ready=1 every cycle → one out_valid payload per cycle, no bubbles; if EX_MEM_FWD_EN is defined, fwd_data equals the prior result.

Source files
------------

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX->MEM pipeline latch with mul/div stall, skid buffer, branch redirect and timeout flag; defining EX_MEM_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs
module ex_mem_latch #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 5,
  parameter int RD_W       = 5,
  parameter int MEMCTL_W   = 3,
  parameter int MD_TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_md,
  input  logic                is_branch,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_is_zero,
  input  logic                alu_md_ready,
  input  logic [DATA_W-1:0]   br_target,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [RD_W-1:0]     rd_in,
  input  logic [MEMCTL_W-1:0] memctl_in,
  output logic                stall_ex,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_store,
  output logic [RD_W-1:0]     out_rd,
  output logic [MEMCTL_W-1:0] out_memctl,
  output logic                branch_taken,
  output logic [DATA_W-1:0]   branch_pc,
`ifdef EX_MEM_FWD_EN
  output logic                fwd_valid,
  output logic [RD_W-1:0]     fwd_rd,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic                md_err
);
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1) + (CTRL_W > 0 ? 0 : 1);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(MD_TIMEOUT);
  typedef enum logic {IDLE, MD_WAIT} state_t;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 pending;
  logic [DATA_W-1:0]    skid_result, skid_store;
  logic [RD_W-1:0]      skid_rd;
  logic [MEMCTL_W-1:0]  skid_memctl;
  logic                 slot_free, accept, md_start, md_done, md_skid, drain, taken;
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = state == IDLE && slot_free && !is_md && !pending;
    accept    = in_valid && in_ready;
    taken     = accept && is_branch && alu_is_zero;
    md_start  = state == IDLE && !pending && in_valid && is_md;
    md_done   = state == MD_WAIT && alu_md_ready && slot_free;
    md_skid   = state == MD_WAIT && alu_md_ready && !slot_free;
    drain     = pending && slot_free;
    stall_ex  = md_start || pending || (state == MD_WAIT && !md_done);
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= 1'b0;
      md_err       <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_store    <= '0;
      out_rd       <= '0;
      out_memctl   <= '0;
      branch_taken <= 1'b0;
      branch_pc    <= '0;
      skid_result  <= '0;
      skid_store   <= '0;
      skid_rd      <= '0;
      skid_memctl  <= '0;
    end else begin
      if (slot_free) out_valid <= accept || md_done || drain;
      if (accept) begin
        out_result <= alu_result;
        out_store  <= store_data;
        out_rd     <= (is_branch && !alu_is_zero) ? '0 : rd_in;
        out_memctl <= memctl_in;
      end else if (md_done) begin
        out_result <= alu_result;
        out_store  <= store_data;
        out_rd     <= rd_in;
        out_memctl <= memctl_in;
      end else if (drain) begin
        out_result <= skid_result;
        out_store  <= skid_store;
        out_rd     <= skid_rd;
        out_memctl <= skid_memctl;
      end
      if (md_skid) begin
        skid_result <= alu_result;
        skid_store  <= store_data;
        skid_rd     <= rd_in;
        skid_memctl <= memctl_in;
      end
      branch_taken <= taken;
      if (taken) branch_pc <= br_target;
      pending <= md_skid || (pending && !slot_free);
      md_err  <= md_err || (state == MD_WAIT && !alu_md_ready && cnt == TMAX - 1'b1);
      if (md_start) cnt <= '0;
      else if (state == MD_WAIT && cnt != TMAX) cnt <= cnt + 1'b1;
      state <= md_start ? MD_WAIT : (state == MD_WAIT && alu_md_ready) ? IDLE : state;
    end
  end
`ifdef EX_MEM_FWD_EN
  assign fwd_valid = out_valid && |out_rd && !out_memctl[MEMCTL_W-1];
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`endif
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: directed assertion-based bench for ex_mem_latch
module tb_ex_mem_latch;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, is_md, is_branch, alu_is_zero, alu_md_ready;
  logic [31:0] alu_result, br_target, store_data, out_result, out_store, branch_pc;
  logic [4:0]  rd_in, out_rd;
  logic [2:0]  memctl_in, out_memctl;
  logic        stall_ex, out_valid, out_ready, branch_taken, md_err;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ex_mem_latch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .is_md(is_md),
    .is_branch(is_branch), .alu_result(alu_result), .alu_is_zero(alu_is_zero),
    .alu_md_ready(alu_md_ready), .br_target(br_target), .store_data(store_data),
    .rd_in(rd_in), .memctl_in(memctl_in), .stall_ex(stall_ex), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store(out_store), .out_rd(out_rd),
    .out_memctl(out_memctl), .branch_taken(branch_taken), .branch_pc(branch_pc),
`ifdef EX_MEM_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .md_err(md_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; is_md = 1'b0; is_branch = 1'b0; alu_is_zero = 1'b0;
    alu_md_ready = 1'b0; alu_result = '0; br_target = '0; store_data = '0; rd_in = '0;
    memctl_in = '0; out_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_md_err", 32'(md_err), 0);
    chk("rst_stall", 32'(stall_ex), 0);
    chk("rst_branch_taken", 32'(branch_taken), 0);
    chk("rst_branch_pc", branch_pc, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; alu_result = 32'h7; rd_in = 5'd5; store_data = 32'hAA; memctl_in = 3'd1; out_ready = 1'b1;
    #1;
    chk("add_in_ready", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 1);
    chk("add_result", out_result, 32'h7);
    chk("add_rd", 32'(out_rd), 5);
    chk("add_store", out_store, 32'hAA);
    chk("add_memctl", 32'(out_memctl), 1);
    chk("add_no_branch", 32'(branch_taken), 0);
    in_valid = 1'b1; is_branch = 1'b1; alu_is_zero = 1'b1; br_target = 32'h100; rd_in = 5'd0;
    alu_result = 32'h55; memctl_in = 3'd0;
    tick;
    in_valid = 1'b0; is_branch = 1'b0; alu_is_zero = 1'b0;
    chk("beq_taken", 32'(branch_taken), 1);
    chk("beq_pc", branch_pc, 32'h100);
    chk("beq_valid", 32'(out_valid), 1);
    tick;
    chk("beq_pulse_end", 32'(branch_taken), 0);
    chk("beq_drained", 32'(out_valid), 0);
    in_valid = 1'b1; is_branch = 1'b1; alu_is_zero = 1'b0; rd_in = 5'd7; alu_result = 32'h9;
    tick;
    in_valid = 1'b0; is_branch = 1'b0;
    chk("bne_valid", 32'(out_valid), 1);
    chk("bne_rd_zero", 32'(out_rd), 0);
    chk("bne_not_taken", 32'(branch_taken), 0);
    tick;
    in_valid = 1'b1; is_md = 1'b1; rd_in = 5'd3; store_data = 32'h0; alu_result = 32'h0;
    #1;
    chk("mul_stall_c0", 32'(stall_ex), 1);
    chk("mul_in_ready_c0", 32'(in_ready), 0);
    for (int i = 1; i <= 32; i++) begin
      tick;
      chk($sformatf("mul_stall_c%0d", i), 32'(stall_ex), 1);
    end
    tick;
    alu_md_ready = 1'b1; alu_result = 32'h30;
    #1;
    chk("mul_stall_pulse", 32'(stall_ex), 0);
    tick;
    alu_md_ready = 1'b0; in_valid = 1'b0; is_md = 1'b0;
    #1;
    chk("mul_valid", 32'(out_valid), 1);
    chk("mul_result", out_result, 32'h30);
    chk("mul_rd", 32'(out_rd), 3);
    chk("mul_stall_after", 32'(stall_ex), 0);
    alu_md_ready = 1'b1;
    tick;
    alu_md_ready = 1'b0;
    chk("idle_pulse_ignored", 32'(out_valid), 0);
    chk("idle_pulse_stall", 32'(stall_ex), 0);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_result = 32'h11; rd_in = 5'd2; store_data = 32'h22; memctl_in = 3'd2;
    tick;
    in_valid = 1'b1; is_md = 1'b1; rd_in = 5'd4; store_data = 32'h44; memctl_in = 3'd3; alu_result = 32'h0;
    #1;
    chk("bp_held_valid", 32'(out_valid), 1);
    chk("bp_held_result", out_result, 32'h11);
    tick;
    tick;
    alu_md_ready = 1'b1; alu_result = 32'h99;
    #1;
    chk("bp_pulse_stall", 32'(stall_ex), 1);
    tick;
    alu_md_ready = 1'b0; in_valid = 1'b0; is_md = 1'b0; alu_result = 32'h0;
    #1;
    chk("bp_skid_result_hold", out_result, 32'h11);
    chk("bp_skid_rd_hold", 32'(out_rd), 2);
    chk("bp_skid_stall", 32'(stall_ex), 1);
    chk("bp_skid_in_ready", 32'(in_ready), 0);
    tick;
    chk("bp_hold2_result", out_result, 32'h11);
    chk("bp_hold2_store", out_store, 32'h22);
    chk("bp_hold2_stall", 32'(stall_ex), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_drain_stall", 32'(stall_ex), 1);
    tick;
    chk("bp_drain_valid", 32'(out_valid), 1);
    chk("bp_drain_result", out_result, 32'h99);
    chk("bp_drain_rd", 32'(out_rd), 4);
    chk("bp_drain_store", out_store, 32'h44);
    chk("bp_drain_memctl", 32'(out_memctl), 3);
    chk("bp_drain_stall_low", 32'(stall_ex), 0);
    tick;
    chk("bp_empty", 32'(out_valid), 0);
    memctl_in = 3'd0; store_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; alu_result = 32'h100 + 32'(k); rd_in = 5'(k + 1);
      tick;
      chk($sformatf("b2b_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("b2b_result%0d", k), out_result, 32'h100 + 32'(k));
`ifdef EX_MEM_FWD_EN
      chk($sformatf("b2b_fwd_valid%0d", k), 32'(fwd_valid), 1);
      chk($sformatf("b2b_fwd_data%0d", k), fwd_data, 32'h100 + 32'(k));
      chk($sformatf("b2b_fwd_rd%0d", k), 32'(fwd_rd), 32'(k + 1));
`endif
    end
    in_valid = 1'b0;
    tick;
    chk("b2b_empty", 32'(out_valid), 0);
    in_valid = 1'b1; is_md = 1'b1; rd_in = 5'd9;
    tick;
    for (int i = 0; i < 39; i++) tick;
    chk("to_err_before", 32'(md_err), 0);
    tick;
    chk("to_err_set", 32'(md_err), 1);
    tick;
    tick;
    tick;
    chk("to_err_sticky", 32'(md_err), 1);
    chk("to_stall_held", 32'(stall_ex), 1);
    rst_n = 1'b1; in_valid = 1'b0; is_md = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", 32'(md_err), 0);
    chk("to_rst_valid", 32'(out_valid), 0);
    chk("to_rst_stall", 32'(stall_ex), 0);
    chk("to_rst_idle", 32'(in_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
